// File: rtl/power_gating_pkg.sv
// Shared power-gating definitions: FSM state encoding used by the request
// manager and by the gating controller bench.
package power_gating_pkg;

    localparam int PG_STATE_W = 2;

    typedef enum logic [PG_STATE_W-1:0] {
        PG_OFF     = 2'd0,
        PG_REQ_ON  = 2'd1,
        PG_ON      = 2'd2,
        PG_REQ_OFF = 2'd3
    } pg_state_t;

    // True while a request is outstanding towards the gating controller.
    function automatic logic pg_in_handshake(pg_state_t s);
        return (s == PG_REQ_ON) || (s == PG_REQ_OFF);
    endfunction

endpackage

// File: rtl/power_request_manager_if.sv
// Request/acknowledge handshake between the request manager (master) and
// the power-gating controller (slave).
interface power_request_manager_if;

    logic power_on_req;
    logic power_off_req;
    logic power_on_ack;
    logic power_off_ack;

    modport master (
        output power_on_req,
        output power_off_req,
        input  power_on_ack,
        input  power_off_ack
    );

    modport slave (
        input  power_on_req,
        input  power_off_req,
        output power_on_ack,
        output power_off_ack
    );

endinterface

// File: rtl/pg_idle_counter.sv
// Idle counter for the ON state: clears on activity or outside ON,
// saturates at all-ones, flags expiry on an exact match with the limit.
module pg_idle_counter #(
    parameter int IDLE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              activity,
    input  logic [IDLE_W-1:0] limit,
    output logic              expire
);

    logic [IDLE_W-1:0] count;

    // Holding the count at zero outside ON guarantees a fresh start on entry.
    always_ff @(posedge clk) begin
        if (rst || !run)
            count <= '0;
        else if (activity)
            count <= '0;
        else if (count != '1)
            count <= count + IDLE_W'(1);
    end

    // Exact match: a limit lowered below the count waits for a clear and re-climb.
    assign expire = run && !activity && (limit != '0) && (count == limit);

endmodule

// File: rtl/power_request_manager.sv
// Power-domain request manager: sequences on/off requests to the gating
// controller from wake/busy/idle status, with replay of wakes during power-down.
module power_request_manager
    import power_gating_pkg::*;
#(
    parameter int IDLE_W      = 16,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wake_req,
    input  logic                  busy,
    input  logic                  force_on,
    input  logic [IDLE_W-1:0]     idle_limit,
    power_request_manager_if.master ctrl,
    output logic                  domain_ready,
    output logic                  wake_pending,
    output logic                  seq_timeout,
    output logic [PG_STATE_W-1:0] state_o
);

    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    pg_state_t     state, next_state;
    logic          activity;
    logic          idle_expire;
    logic          hold_state;
    logic [AW-1:0] ack_timer;

    assign activity = wake_req | busy | force_on;

    pg_idle_counter #(.IDLE_W(IDLE_W)) u_idle (
        .clk      (clk),
        .rst      (rst),
        .run      (state == PG_ON),
        .activity (activity),
        .limit    (idle_limit),
        .expire   (idle_expire)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= PG_OFF;
        else
            state <= next_state;
    end

    // A power-down in progress is never aborted; wakes are queued instead.
    always_comb begin
        next_state = state;
        case (state)
            PG_OFF:     if (wake_req || force_on || wake_pending) next_state = PG_REQ_ON;
            PG_REQ_ON:  if (ctrl.power_on_ack)                    next_state = PG_ON;
            PG_ON:      if (idle_expire)                          next_state = PG_REQ_OFF;
            PG_REQ_OFF: if (ctrl.power_off_ack)                   next_state = PG_OFF;
            default:                                              next_state = PG_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            wake_pending <= 1'b0;
        else if (state == PG_REQ_OFF && (wake_req || force_on))
            wake_pending <= 1'b1;
        else if (state == PG_REQ_ON && ctrl.power_on_ack)
            wake_pending <= 1'b0;
    end

    assign hold_state = pg_in_handshake(state) && (next_state == state);

    // Timer saturates at the limit so the timeout flag is set exactly once.
    always_ff @(posedge clk) begin
        if (rst || !hold_state)
            ack_timer <= '0;
        else if (ack_timer != AW'(ACK_TIMEOUT))
            ack_timer <= ack_timer + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            seq_timeout <= 1'b0;
        else if (hold_state && ack_timer == AW'(ACK_TIMEOUT - 1))
            seq_timeout <= 1'b1;
    end

    assign ctrl.power_on_req  = (state == PG_REQ_ON);
    assign ctrl.power_off_req = (state == PG_REQ_OFF);
    assign domain_ready       = (state == PG_ON);
    assign state_o            = state;

endmodule

// File: tb/tb_power_request_manager.sv
// Directed bench for power_request_manager: handshake timing, idle power-down,
// wake replay, ack timeout, force_on hold and reset behaviour.
module tb_power_request_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic        wake_req;
    logic        busy;
    logic        force_on;
    logic [15:0] idle_limit;
    logic        domain_ready;
    logic        wake_pending;
    logic        seq_timeout;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    power_request_manager_if pg_if();

    power_request_manager #(.IDLE_W(16), .ACK_TIMEOUT(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .wake_req     (wake_req),
        .busy         (busy),
        .force_on     (force_on),
        .idle_limit   (idle_limit),
        .ctrl         (pg_if),
        .domain_ready (domain_ready),
        .wake_pending (wake_pending),
        .seq_timeout  (seq_timeout),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs driven 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bring_up();
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        pg_if.power_on_ack = 1'b1;
        tick();
    endtask

    task automatic off_ack();
        pg_if.power_off_ack = 1'b1;
        pg_if.power_on_ack  = 1'b0;
        tick();
        pg_if.power_off_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        wake_req = 1'b0;
        busy = 1'b0;
        force_on = 1'b0;
        idle_limit = 16'd20;
        pg_if.power_on_ack  = 1'b0;
        pg_if.power_off_ack = 1'b0;
        repeat (3) tick();
        check("rst_state", state_o, 2'd0);
        check("rst_outs", {pg_if.power_on_req, pg_if.power_off_req, domain_ready,
                           wake_pending, seq_timeout}, 5'b0);
        rst = 1'b0;
        tick();
        check("off_idle", state_o, 2'd0);

        // Wake for one cycle, ack after 12 cycles in REQ_ON
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        check("wake_on_req", {state_o, pg_if.power_on_req, pg_if.power_off_req}, {2'd1, 2'b10});
        repeat (11) tick();
        check("req_on_wait", {pg_if.power_on_req, domain_ready}, 2'b10);
        pg_if.power_on_ack = 1'b1;
        tick();
        check("on_ready", {state_o, domain_ready, pg_if.power_on_req}, {2'd2, 2'b10});

        // Quiet ON with limit 20: off request 21 cycles after entry
        for (int i = 1; i <= 20; i++) tick();
        check("idle_20_no_off", {state_o, pg_if.power_off_req}, {2'd2, 1'b0});
        tick();
        check("idle_21_off", {state_o, pg_if.power_off_req, pg_if.power_on_req, domain_ready},
              {2'd3, 3'b100});
        repeat (3) tick();
        check("req_off_hold", {state_o, pg_if.power_off_req}, {2'd3, 1'b1});
        off_ack();
        check("off_after_ack", {state_o, pg_if.power_off_req}, {2'd0, 1'b0});

        // Stray acks in OFF are ignored
        pg_if.power_on_ack  = 1'b1;
        pg_if.power_off_ack = 1'b1;
        tick();
        pg_if.power_on_ack  = 1'b0;
        pg_if.power_off_ack = 1'b0;
        check("stray_ack_off", state_o, 2'd0);

        // Busy at count 15 restarts the idle count
        bring_up();
        check("up2_on", state_o, 2'd2);
        repeat (15) tick();
        busy = 1'b1;
        tick();
        busy = 1'b0;
        repeat (20) tick();
        check("busy_20_no_off", state_o, 2'd2);
        tick();
        check("busy_21_off", {state_o, pg_if.power_off_req}, {2'd3, 1'b1});
        off_ack();

        // Wake during REQ_OFF is queued and replayed
        idle_limit = 16'd3;
        bring_up();
        repeat (4) tick();
        check("lim3_req_off", state_o, 2'd3);
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        check("wake_pend_set", {state_o, wake_pending, pg_if.power_off_req}, {2'd3, 2'b11});
        off_ack();
        check("replay_off", {state_o, wake_pending, pg_if.power_on_req}, {2'd0, 2'b10});
        tick();
        check("replay_req_on", {state_o, pg_if.power_on_req}, {2'd1, 1'b1});
        pg_if.power_on_ack = 1'b1;
        tick();
        check("replay_on", {state_o, wake_pending, domain_ready}, {2'd2, 2'b01});

        // Limit lowered below the running count waits for a clear
        idle_limit = 16'd200;
        repeat (10) tick();
        idle_limit = 16'd5;
        repeat (10) tick();
        check("lim_below_cnt", state_o, 2'd2);
        busy = 1'b1;
        tick();
        busy = 1'b0;
        repeat (5) tick();
        check("lim5_no_off", state_o, 2'd2);
        tick();
        check("lim5_off", state_o, 2'd3);
        off_ack();

        // No ack in REQ_ON: timeout after 256 cycles, request held
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        repeat (255) tick();
        check("to_255", {seq_timeout, pg_if.power_on_req}, 2'b01);
        tick();
        check("to_256", {state_o, seq_timeout, pg_if.power_on_req}, {2'd1, 2'b11});
        repeat (4) tick();
        check("to_hold", {state_o, pg_if.power_on_req}, {2'd1, 1'b1});
        pg_if.power_on_ack = 1'b1;
        tick();
        check("late_ack_on", {state_o, seq_timeout}, {2'd2, 1'b1});

        // force_on holds the domain on even with a 1-cycle limit
        force_on = 1'b1;
        idle_limit = 16'd1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            check("force_hold", {state_o, pg_if.power_on_req & pg_if.power_off_req}, {2'd2, 1'b0});
        end
        force_on = 1'b0;
        tick();
        check("force_rel_1", state_o, 2'd2);
        tick();
        check("force_rel_2", state_o, 2'd3);
        force_on = 1'b1;
        tick();
        force_on = 1'b0;
        check("force_pend", {state_o, wake_pending}, {2'd3, 1'b1});
        off_ack();
        tick();
        check("force_replay", {state_o, pg_if.power_on_req}, {2'd1, 1'b1});

        // Reset mid-REQ_ON drops the request next cycle
        rst = 1'b1;
        tick();
        check("rst_mid_req", {state_o, pg_if.power_on_req, pg_if.power_off_req,
                              wake_pending, seq_timeout}, {2'd0, 4'b0});
        rst = 1'b0;

        // Limit 0 disables automatic power-down
        idle_limit = 16'd0;
        bring_up();
        repeat (100) tick();
        check("lim0_stay_on", {state_o, domain_ready}, {2'd2, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
